// File: rtl/psum_acc_if.sv
// Handshake bundle between the PE arithmetic unit, psum_acc and the psum chain.
// slave = accumulator side, master = upstream/downstream driver side.
interface psum_acc_if #(
   parameter int IWd   = 16,
   parameter int OWd   = 24,
   parameter int LenWd = 8
) ();
   logic [LenWd-1:0]     i_cont_len;
   logic                 i_cont_stall;
   logic                 i_cont_clear;
   logic signed [IWd-1:0] i_sum;
   logic                 i_sum_rdy;
   logic                 o_sum_ack;
   logic                 i_sum_zero;
   logic signed [OWd-1:0] o_psum;
   logic                 o_psum_rdy;
   logic                 i_psum_ack;
   logic                 o_psum_zero;
   logic                 o_busy;

   modport slave (
      input  i_cont_len, i_cont_stall, i_cont_clear,
      input  i_sum, i_sum_rdy, i_sum_zero, i_psum_ack,
      output o_sum_ack, o_psum, o_psum_rdy, o_psum_zero, o_busy
   );

   modport master (
      output i_cont_len, i_cont_stall, i_cont_clear,
      output i_sum, i_sum_rdy, i_sum_zero, i_psum_ack,
      input  o_sum_ack, o_psum, o_psum_rdy, o_psum_zero, o_busy
   );
endinterface

// File: rtl/psum_acc.sv
// Partial-sum accumulator: sums i_cont_len+1 signed beats into one psum (PSUM_SAT_EN selects saturating adds).
// Latency: o_psum_rdy rises the cycle after the last beat; backpressure stalls only the last beat of a group.
// Backpressure: one-entry output register; a drain and a reload may happen in the same cycle.
module psum_acc #(
   parameter int IWd   = 16,
   parameter int OWd   = 24,
   parameter int LenWd = 8
) (
   input logic       i_clk,
   input logic       i_rst,
   psum_acc_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

   state_t           st, st_next;
   logic [OWd-1:0]   acc, acc_next, ext, base;
   logic [LenWd-1:0] cnt, len_r, lim;
   logic             zall, zall_next;
   logic             last_pending, sum_ack, xfer, drain;
   logic [OWd-1:0]   out_dat;
   logic             out_zero, out_vld;
`ifdef PSUM_SAT_EN
   logic             sat, sat_next;
   logic [OWd:0]     wide;
`endif

   always_comb begin
      st_next      = st;
      ext          = bus.i_sum_zero ? '0 : {{(OWd-IWd){bus.i_sum[IWd-1]}}, bus.i_sum};
      lim          = (st == IDLE) ? bus.i_cont_len : len_r;
      last_pending = (cnt == lim);
      // Only a last beat needs the output slot, so only it waits on the downstream.
      sum_ack      = bus.i_cont_stall & ~i_rst & ~bus.i_cont_clear &
                     ~(last_pending & out_vld & ~bus.i_psum_ack);
      xfer         = bus.i_sum_rdy & sum_ack;
      drain        = out_vld & bus.i_psum_ack;
      base         = (st == IDLE) ? '0 : acc;
      zall_next    = (st == IDLE) ? bus.i_sum_zero : (zall & bus.i_sum_zero);
`ifdef PSUM_SAT_EN
      wide     = {base[OWd-1], base} + {ext[OWd-1], ext};
      sat_next = (st == IDLE) ? 1'b0 : sat;
      if (sat_next) begin
         acc_next = acc;
      end else if (wide[OWd] != wide[OWd-1]) begin
         sat_next = 1'b1;
         acc_next = wide[OWd] ? {1'b1, {(OWd-1){1'b0}}} : {1'b0, {(OWd-1){1'b1}}};
      end else begin
         acc_next = wide[OWd-1:0];
      end
`else
      acc_next = base + ext;
`endif
      if (xfer) st_next = last_pending ? IDLE : ACC;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || bus.i_cont_clear) st <= IDLE;
      else if (bus.i_cont_stall)     st <= st_next;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || bus.i_cont_clear) begin
         acc      <= '0;
         cnt      <= '0;
         len_r    <= '0;
         zall     <= 1'b1;
         out_dat  <= '0;
         out_zero <= 1'b1;
         out_vld  <= 1'b0;
`ifdef PSUM_SAT_EN
         sat      <= 1'b0;
`endif
      end else if (bus.i_cont_stall) begin
         if (drain) out_vld <= 1'b0;
         if (xfer) begin
            acc  <= acc_next;
            zall <= zall_next;
`ifdef PSUM_SAT_EN
            sat  <= sat_next;
`endif
            if (st == IDLE) len_r <= bus.i_cont_len;
            if (last_pending) begin
               cnt      <= '0;
               out_dat  <= acc_next;
               out_zero <= zall_next;
               out_vld  <= 1'b1;
            end else begin
               cnt <= cnt + LenWd'(1);
            end
         end
      end
   end

   assign bus.o_sum_ack   = sum_ack;
   assign bus.o_psum      = out_dat;
   assign bus.o_psum_zero = out_zero;
   assign bus.o_psum_rdy  = out_vld;
   assign bus.o_busy      = (st == ACC);
endmodule
